// File: rtl/leds_pio_pkg.sv
// Shared register map and STATUS layout for the leds_pio_ext LED output PIO.
package leds_pio_pkg;

   localparam logic [2:0] ADDR_DATA         = 3'd0;
   localparam logic [2:0] ADDR_SET          = 3'd1;
   localparam logic [2:0] ADDR_CLR          = 3'd2;
   localparam logic [2:0] ADDR_TOGGLE       = 3'd3;
   localparam logic [2:0] ADDR_BLINK_MASK   = 3'd4;
   localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd5;
   localparam logic [2:0] ADDR_STATUS       = 3'd6;

   localparam int unsigned STATUS_PHASE_BIT   = 0;
   localparam int unsigned STATUS_RUNNING_BIT = 1;

endpackage

// File: rtl/leds_pio_ext_if.sv
// Avalon-MM slave bus bundle for leds_pio_ext (zero-wait-state, read latency 0).
interface leds_pio_ext_if;

   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/pio_blink_timer.sv
// Blink half-period timer: reloadable down-counter that flips phase at terminal count.
module pio_blink_timer #(
   parameter int unsigned PERIOD_W = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [PERIOD_W-1:0] load_value,
   output logic                phase,
   output logic                running,
   output logic [PERIOD_W-1:0] period
);

   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                phase_q, phase_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_q <= '0;
         cnt_q    <= '0;
         phase_q  <= 1'b0;
      end else begin
         period_q <= period_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
      end
   end

   // A period write restarts the half-period even if it lands on terminal count.
   always_comb begin
      period_d = period_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      if (load) begin
         period_d = load_value;
         cnt_d    = load_value;
         phase_d  = 1'b0;
      end else if (period_q == '0) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == '0) begin
         cnt_d   = period_q;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign phase   = phase_q;
   assign running = (period_q != '0);
   assign period  = period_q;

endmodule

// File: rtl/leds_pio_ext.sv
// LED output PIO with atomic SET/CLR/TOGGLE writes; the blink engine is built only
// when LEDS_PIO_EXT_BLINK_EN is defined.
module leds_pio_ext
   import leds_pio_pkg::*;
#(
   parameter int unsigned WIDTH       = 14,
   parameter int unsigned PERIOD_W    = 24,
   parameter logic [31:0] RESET_VALUE = 32'h0
) (
   input  logic             clk,
   input  logic             reset,
   leds_pio_ext_if.slave    bus,
   output logic [WIDTH-1:0] out_port
);

   logic             wr_en;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] data_q, data_d;

   assign wr_en = bus.chipselect && !bus.write_n;
   assign wd    = bus.writedata[WIDTH-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= RESET_VALUE[WIDTH-1:0];
      end else begin
         data_q <= data_d;
      end
   end

   always_comb begin
      data_d = data_q;
      if (wr_en) begin
         case (bus.address)
            ADDR_DATA:   data_d = wd;
            ADDR_SET:    data_d = data_q | wd;
            ADDR_CLR:    data_d = data_q & ~wd;
            ADDR_TOGGLE: data_d = data_q ^ wd;
            default:     ;
         endcase
      end
   end

`ifdef LEDS_PIO_EXT_BLINK_EN
   logic [WIDTH-1:0]    mask_q, mask_d;
   logic                phase;
   logic                running;
   logic [PERIOD_W-1:0] period;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q <= '0;
      end else begin
         mask_q <= mask_d;
      end
   end

   always_comb begin
      mask_d = mask_q;
      if (wr_en && (bus.address == ADDR_BLINK_MASK)) begin
         mask_d = wd;
      end
   end

   pio_blink_timer #(
      .PERIOD_W (PERIOD_W)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (wr_en && (bus.address == ADDR_BLINK_PERIOD)),
      .load_value (bus.writedata[PERIOD_W-1:0]),
      .phase      (phase),
      .running    (running),
      .period     (period)
   );

   assign out_port = data_q ^ (mask_q & {WIDTH{phase}});
`else
   assign out_port = data_q;
`endif

   // Write-only and reserved addresses read back as zero.
   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         ADDR_DATA: bus.readdata[WIDTH-1:0] = data_q;
`ifdef LEDS_PIO_EXT_BLINK_EN
         ADDR_BLINK_MASK:   bus.readdata[WIDTH-1:0]    = mask_q;
         ADDR_BLINK_PERIOD: bus.readdata[PERIOD_W-1:0] = period;
         ADDR_STATUS: begin
            bus.readdata[STATUS_PHASE_BIT]   = phase;
            bus.readdata[STATUS_RUNNING_BIT] = running;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_leds_pio_ext.sv
// Scoreboard bench for leds_pio_ext: stimulus queues expectations, a negedge monitor checks them.
module tb_leds_pio_ext;
   import leds_pio_pkg::*;

   localparam int unsigned WIDTH    = 14;
   localparam int unsigned PERIOD_W = 24;

   typedef struct {
      string       name;
      bit          is_rd;
      logic [31:0] val;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [WIDTH-1:0] out_port;
   exp_t             sb[$];
   int               total = 0;
   int               bad = 0;

   leds_pio_ext_if bus ();

   leds_pio_ext #(
      .WIDTH       (WIDTH),
      .PERIOD_W    (PERIOD_W),
      .RESET_VALUE (32'h0000_0055)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .out_port (out_port)
   );

   always #5 clk = ~clk;

   // Monitor: everything queued during a cycle is checked at that cycle's falling edge.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t e;
         logic [31:0] act;
         e = sb.pop_front();
         act = e.is_rd ? bus.readdata : {{(32-WIDTH){1'b0}}, out_port};
         total++;
         if (act !== e.val) begin
            bad++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      step();
   endtask

   task automatic expect_out(input logic [31:0] v, input string nm);
      sb.push_back('{name: nm, is_rd: 1'b0, val: v});
   endtask

   task automatic expect_rd(input logic [2:0] a, input logic [31:0] v, input string nm);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      sb.push_back('{name: nm, is_rd: 1'b1, val: v});
   endtask

   initial begin
      bus.address    = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      expect_out(32'h55, "rst_out");   expect_rd(ADDR_DATA, 32'h55, "rst_data");   step();
      expect_rd(ADDR_BLINK_MASK, 32'h0, "rst_mask");     step();
      expect_rd(ADDR_BLINK_PERIOD, 32'h0, "rst_period"); step();
      expect_rd(ADDR_STATUS, 32'h0, "rst_status");       step();

      // Atomic write sequence; upper writedata bits must be ignored.
      bus_write(ADDR_DATA, 32'hFFFF_00F0);  expect_out(32'h0F0, "seq_data");   step();
      bus_write(ADDR_SET, 32'h0003);        expect_out(32'h0F3, "seq_set");    step();
      bus_write(ADDR_CLR, 32'h0010);        expect_out(32'h0E3, "seq_clr");    step();
      bus_write(ADDR_TOGGLE, 32'h0101);     expect_out(32'h1E2, "seq_toggle"); step();
      expect_rd(ADDR_SET, 32'h0, "rd_set");       step();
      expect_rd(ADDR_CLR, 32'h0, "rd_clr");       step();
      expect_rd(ADDR_TOGGLE, 32'h0, "rd_toggle"); step();
      expect_rd(ADDR_DATA, 32'h1E2, "rd_data");   step();
      bus_write(3'd7, 32'h3FFF);
      expect_out(32'h1E2, "rsvd_wr");  expect_rd(3'd7, 32'h0, "rsvd_rd"); step();

`ifdef LEDS_PIO_EXT_BLINK_EN
      bus_write(ADDR_DATA, 32'h0);
      bus_write(ADDR_BLINK_MASK, 32'h000F);
      bus_write(ADDR_BLINK_PERIOD, 32'd3);
      // Phase flips every 4 cycles, first flip 4 cycles after the period write.
      for (int k = 0; k < 13; k++) begin
         expect_out(((k / 4) % 2) ? 32'h00F : 32'h000, "blink_out");
         expect_rd(ADDR_STATUS, ((k / 4) % 2) ? 32'h3 : 32'h2, "blink_status");
         step();
      end

      // Period write landing on terminal count wins over the flip.
      bus_write(ADDR_BLINK_PERIOD, 32'd3);
      for (int k = 0; k < 3; k++) begin
         expect_out(32'h0, "pre_tc");
         step();
      end
      bus_write(ADDR_BLINK_PERIOD, 32'd5);
      for (int k = 0; k < 7; k++) begin
         expect_out((k == 6) ? 32'h00F : 32'h000, "reload_out");
         if (k == 0) expect_rd(ADDR_BLINK_PERIOD, 32'd5, "reload_period");
         if (k == 1) expect_rd(ADDR_STATUS, 32'h2, "reload_status");
         step();
      end

      // TOGGLE coinciding with a phase flip: both inversions cancel on out_port.
      bus_write(ADDR_BLINK_MASK, 32'h0001);
      bus_write(ADDR_BLINK_PERIOD, 32'd3);
      for (int k = 0; k < 3; k++) begin
         expect_out(32'h0, "pre_coinc");
         step();
      end
      bus_write(ADDR_TOGGLE, 32'h0001);
      for (int k = 0; k < 5; k++) begin
         expect_out((k == 4) ? 32'h1 : 32'h0, "coinc_out");
         if (k == 0) expect_rd(ADDR_DATA, 32'h1, "coinc_data");
         if (k == 1) expect_rd(ADDR_STATUS, 32'h3, "coinc_status");
         if (k == 2) expect_rd(ADDR_BLINK_MASK, 32'h1, "coinc_mask");
         step();
      end
`else
      bus_write(ADDR_BLINK_MASK, 32'h3FFF);
      bus_write(ADDR_BLINK_PERIOD, 32'd1);
      for (int k = 0; k < 6; k++) begin
         expect_out(32'h1E2, "noblink_out");
         if (k == 0) expect_rd(ADDR_BLINK_MASK, 32'h0, "noblink_mask");
         if (k == 1) expect_rd(ADDR_BLINK_PERIOD, 32'h0, "noblink_period");
         if (k == 2) expect_rd(ADDR_STATUS, 32'h0, "noblink_status");
         step();
      end
      bus_write(ADDR_DATA, 32'h0123);
      expect_out(32'h123, "noblink_data"); step();
      expect_out(32'h123, "noblink_hold"); step();
`endif

      // Asynchronous reset in the middle of activity.
      reset = 1'b1;
      expect_out(32'h55, "mid_rst_out");  expect_rd(ADDR_DATA, 32'h55, "mid_rst_data"); step();
      expect_rd(ADDR_BLINK_MASK, 32'h0, "mid_rst_mask");     step();
      expect_rd(ADDR_BLINK_PERIOD, 32'h0, "mid_rst_period"); step();
      expect_rd(ADDR_STATUS, 32'h0, "mid_rst_status");       step();
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         expect_out(32'h55, "post_rst_out");
         step();
      end

      step();
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
